// File: rtl/minterm_sweeper.sv
// Handshaked sweeper: drives {x,y,w,z} through minterms 0..15 and captures s into a truth table.
// Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching minterm.
module minterm_sweeper #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h64D4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic [3:0]  m,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail,
  output logic        any_fail
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] tt_next;
  logic        mismatch;
  logic        stop;

  assign x = m[3];
  assign y = m[2];
  assign w = m[1];
  assign z = m[0];

  // tt_next lets pass be computed from the table including the final sample
  always_comb begin
    tt_next    = tt;
    tt_next[m] = s;
    mismatch   = (s != EXPECTED[m]);
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop = (m == 4'd15) || mismatch;
`else
    stop = (m == 4'd15);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      m          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= '0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
      any_fail   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            m          <= '0;
            cnt        <= '0;
            tt         <= '0;
            pass       <= 1'b0;
            fail_count <= '0;
            first_fail <= '0;
            any_fail   <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != LAST_CNT) begin
            cnt <= cnt + 4'd1;
          end else begin
            tt  <= tt_next;
            cnt <= '0;
            if (mismatch) begin
              fail_count <= fail_count + 5'd1;
              if (!any_fail) begin
                first_fail <= m;
                any_fail   <= 1'b1;
              end
            end
            // done is registered here so it is high for the single DONE cycle
            if (stop) begin
              state <= DONE_ST;
              done  <= 1'b1;
              busy  <= 1'b0;
              m     <= '0;
              pass  <= (tt_next == EXPECTED);
            end else begin
              m <= m + 4'd1;
            end
          end
        end
        DONE_ST: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/minterm_sweeper.md
Name: minterm_sweeper

Overview:
- Stimulus-and-capture stage wrapped around a 4-input combinational function block.
- Drives the function's inputs (x, y, w, z) through minterms 0..15. x is the MSB and z the LSB, so minterm m = {x,y,w,z}.
- Samples the function output s for each minterm into a 16-bit truth-table register and compares it against an expected mask.
- Replaces the free-running testbench loop with a synthesizable, handshaked sweeper.

Parameters:
- SETTLE, 1, clock cycles each minterm is held before s is sampled; legal range 1..15.
- EXPECTED, 16'h64D4, expected truth table with bit k = s at minterm k. The default is the target function s = (w&~z)|(~x&y&w)|(~x&y&~z)|(x&y&~w&z).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- s  input  1  output of the function under test (combinational from x,y,w,z)
- x  output  1  function input, minterm bit 3
- y  output  1  function input, minterm bit 2
- w  output  1  function input, minterm bit 1
- z  output  1  function input, minterm bit 0
- m  output  4  current minterm index, equal to {x,y,w,z}
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep ends
- tt  output  16  captured truth table
- pass  output  1  tt == EXPECTED; valid after done
- fail_count  output  5  number of minterms where s != EXPECTED[k]; range 0..16
- first_fail  output  4  lowest failing minterm index
- any_fail  output  1  first_fail is valid

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; settle counter 0.
- States and transitions:
  - IDLE: while start=1, the next edge does the following.
    - State moves to RUN; busy=1.
    - m, and therefore {x,y,w,z}, is set to 0.
    - tt, fail_count, first_fail, any_fail and pass are cleared.
    - Settle counter is set to 0.
  - RUN, counter < SETTLE-1: counter increments; m holds.
  - RUN, counter == SETTLE-1 (the sample edge):
    - tt[m] <= s.
    - If s != EXPECTED[m]: fail_count increments. If any_fail=0, also first_fail <= m and any_fail <= 1.
    - If m < 15: m increments and counter resets to 0.
    - If m == 15: state moves to DONE.
  - DONE, one cycle only: done=1, busy=0, pass=(tt==EXPECTED). m and {x,y,w,z} return to 0. Next edge goes to IDLE.
- Timing and latency:
  - Each minterm is held for exactly SETTLE cycles; s is sampled at the end of that window.
  - done is high in the cycle beginning 16*SETTLE edges after the start-acceptance edge.
  - Total sweep is 16*SETTLE+1 cycles, including DONE.
- Handshake:
  - start is ignored while busy or in DONE.
  - start held high through DONE launches a new sweep on the first IDLE cycle.
- Result hold: tt, pass, fail_count, first_fail and any_fail hold their values from done until the next accepted start.
- Width rules:
  - fail_count is 5 bits so it reaches 16 without wrap.
  - m wraps only via the DONE transition, never by overflow.
- Reset mid-sweep: takes priority over every transition; all state and outputs return to reset values on that edge. A subsequent start sweeps from minterm 0.
- Outputs x, y, w, z and m are registered. No combinational path exists from s to any output.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- When defined: at a sample edge with a mismatch, the minterm is recorded as above and the state moves straight to DONE. Remaining tt bits stay 0, fail_count=1, pass=0.
- When not defined: the full 16-minterm sweep always runs.

Test Plan:
1. Assert reset for 2 cycles -> all outputs 0, busy=0, done=0.
2. SETTLE=1, s fed from the correct target function, start pulsed 1 cycle -> busy high for 16 cycles, done pulse 16 edges after acceptance, tt=16'h64D4, pass=1, fail_count=0, any_fail=0.
3. s tied 0, full sweep (macro off) -> tt=16'h0000, fail_count=7, first_fail=2, any_fail=1, pass=0.
4. SETTLE=3, correct function; start re-pulsed at minterm 5 -> second start ignored, each m value held 3 cycles, done 48 edges after acceptance, tt=16'h64D4.
5. reset asserted while m=9 -> next edge: busy=0, m=0, tt=0. Then start -> sweep restarts at m=0 and completes with pass=1.
6. SWEEP_STOP_ON_FAIL_EN defined, s tied 0 -> DONE entered right after the minterm-2 sample, tt=16'h0000, fail_count=1, first_fail=2, pass=0.
